ascon_squeeze_ctrl: RTL and testbench

Parametrised squeeze-phase controller for Ascon-Hash256, Ascon-XOF128 and Ascon-CXOF128. It sits between the Ascon core and the output AXI4-Stream master, after absorption has completed. It slices each 64-bit rate word into OUT_BYTES-wide beats, requests a permutation between rate blocks, and ends the stream on an exact byte count or, in continuous mode, on an abort.

---
 rtl/ascon_pkg.sv | 31 +++
 rtl/ascon_beat_slicer.sv | 26 ++
 rtl/ascon_squeeze_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_ascon_squeeze_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ascon_pkg.sv
// Shared types and helpers for the Ascon squeeze-phase datapath.
// Holds the squeeze FSM state type, the rate width in bytes and the
// final-beat byte-valid mask helper used by ascon_squeeze_ctrl.
package ascon_pkg;

  typedef enum logic [2:0] {
    SQ_IDLE,
    SQ_LOAD,
    SQ_EMIT,
    SQ_PERM,
    SQ_DONE
  } squeeze_state_t;

  localparam int ASCON_RATE_BYTES = 8;

  // Byte-valid mask for a beat: the low remSat lanes are valid, capped at outBytes lanes.
  // Callers pass remSat = remaining bytes when that is below the beat width,
  // otherwise the beat width itself (giving an all-ones mask).
  function automatic logic [ASCON_RATE_BYTES-1:0] ascon_final_keep(
    input logic [3:0] remSat,
    input int         outBytes
  );
    logic [ASCON_RATE_BYTES-1:0] keep;
    keep = '0;
    for (int i = 0; i < ASCON_RATE_BYTES; i++) begin
      keep[i] = (i < int'(remSat)) && (i < outBytes);
    end
    return keep;
  endfunction

endpackage

// File: rtl/ascon_beat_slicer.sv
// Selects one OUT_BYTES-wide beat out of the 64-bit rate hold register.
// Beat k carries hold bytes [k*OUT_BYTES +: OUT_BYTES], little-endian.
module ascon_beat_slicer
  import ascon_pkg::*;
#(
  parameter int OUT_BYTES = 8,
  parameter int IDX_W     = 1
) (
  input  logic [63:0]            hold_i,
  input  logic [IDX_W-1:0]       idx_i,
  output logic [8*OUT_BYTES-1:0] data_o
);

  localparam int BEATS = ASCON_RATE_BYTES / OUT_BYTES;

  // Beat mux: beat 0 is the default, higher beats override on an index match
  always_comb begin
    data_o = hold_i[8*OUT_BYTES-1:0];
    for (int b = 1; b < BEATS; b++) begin
      if (idx_i == IDX_W'(b)) begin
        data_o = hold_i[b*8*OUT_BYTES +: 8*OUT_BYTES];
      end
    end
  end

endmodule

// File: rtl/ascon_squeeze_ctrl.sv
// Squeeze-phase controller for Ascon-Hash256 / XOF128 / CXOF128.
// Slices each 64-bit rate word into OUT_BYTES beats on an AXI4-Stream master,
// requests p^12 between rate blocks, and ends on an exact byte count or, in
// continuous mode (len_i == 0), on abort_i.
// Optional feature: define ASCON_SQUEEZE_BYTECNT_EN to add byte_count_o.
module ascon_squeeze_ctrl
  import ascon_pkg::*;
#(
  parameter int OUT_BYTES = 8,
  parameter int LEN_W     = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start_i,
  input  logic [LEN_W-1:0]       len_i,
  input  logic                   abort_i,
  output logic                   busy_o,
  output logic                   done_o,
  input  logic [63:0]            rate_i,
  input  logic                   ascon_ready_i,
  output logic                   start_perm_o,
  output logic [8*OUT_BYTES-1:0] m_axis_tdata_o,
  output logic [OUT_BYTES-1:0]   m_axis_tkeep_o,
  output logic                   m_axis_tlast_o,
  output logic                   m_axis_tvalid_o,
  input  logic                   m_axis_tready_i
`ifdef ASCON_SQUEEZE_BYTECNT_EN
  ,
  output logic [63:0]            byte_count_o
`endif
);

  localparam int BEATS = ASCON_RATE_BYTES / OUT_BYTES;
  localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);
  localparam logic [LEN_W-1:0] OB_LEN   = LEN_W'(OUT_BYTES);

  squeeze_state_t state_q, state_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             cont_q, cont_d;
  logic             abortPend_q, abortPend_d;
  logic [63:0]      hold_q, hold_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             permWait_q, permWait_d;
  logic             beatShown_q, beatShown_d;
  logic             shownLast_q, shownLast_d;

  logic                        emitting;
  logic                        handshake;
  logic                        remBelow;
  logic                        beatLast;
  logic                        startPerm;
  logic [3:0]                  remSat;
  logic [ASCON_RATE_BYTES-1:0] keepWide;
  logic [8*OUT_BYTES-1:0]      sliceData;

  ascon_beat_slicer #(
    .OUT_BYTES (OUT_BYTES),
    .IDX_W     (IDX_W)
  ) u_slicer (
    .hold_i (hold_q),
    .idx_i  (idx_q),
    .data_o (sliceData)
  );

  // Beat attributes: a stalled beat keeps the tlast it was first shown with,
  // so a late abort only marks the next freshly presented beat
  always_comb begin
    emitting  = (state_q == SQ_EMIT);
    handshake = emitting && m_axis_tready_i;
    remBelow  = (rem_q < OB_LEN);
    if (cont_q) begin
      beatLast = beatShown_q ? shownLast_q : abortPend_q;
      remSat   = 4'(OUT_BYTES);
    end else begin
      beatLast = (rem_q <= OB_LEN);
      remSat   = remBelow ? rem_q[3:0] : 4'(OUT_BYTES);
    end
    keepWide = ascon_final_keep(remSat, OUT_BYTES);
  end

  // Next-state logic for the squeeze FSM and its datapath registers
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    cont_d      = cont_q;
    abortPend_d = abortPend_q;
    hold_d      = hold_q;
    idx_d       = idx_q;
    permWait_d  = permWait_q;
    beatShown_d = beatShown_q;
    shownLast_d = shownLast_q;
    startPerm   = 1'b0;

    if (abort_i && cont_q && (state_q != SQ_IDLE) && (state_q != SQ_DONE)) begin
      abortPend_d = 1'b1;
    end

    unique case (state_q)
      SQ_IDLE: begin
        if (start_i) begin
          rem_d       = len_i;
          cont_d      = (len_i == '0);
          abortPend_d = 1'b0;
          state_d     = SQ_LOAD;
        end
      end
      SQ_LOAD: begin
        hold_d      = rate_i;
        idx_d       = '0;
        beatShown_d = 1'b0;
        state_d     = SQ_EMIT;
      end
      SQ_EMIT: begin
        if (handshake) begin
          beatShown_d = 1'b0;
          if (!cont_q) begin
            rem_d = rem_q - (remBelow ? rem_q : OB_LEN);
          end
          if (beatLast) begin
            state_d = SQ_DONE;
          end else if (idx_q == LAST_IDX) begin
            state_d = SQ_PERM;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          beatShown_d = 1'b1;
          shownLast_d = beatLast;
        end
      end
      SQ_PERM: begin
        if (!permWait_q) begin
          startPerm  = 1'b1;
          permWait_d = 1'b1;
        end else if (ascon_ready_i) begin
          permWait_d = 1'b0;
          state_d    = SQ_LOAD;
        end
      end
      SQ_DONE: begin
        cont_d      = 1'b0;
        abortPend_d = 1'b0;
        state_d     = SQ_IDLE;
      end
      default: state_d = SQ_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SQ_IDLE;
      rem_q       <= '0;
      cont_q      <= 1'b0;
      abortPend_q <= 1'b0;
      hold_q      <= '0;
      idx_q       <= '0;
      permWait_q  <= 1'b0;
      beatShown_q <= 1'b0;
      shownLast_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      cont_q      <= cont_d;
      abortPend_q <= abortPend_d;
      hold_q      <= hold_d;
      idx_q       <= idx_d;
      permWait_q  <= permWait_d;
      beatShown_q <= beatShown_d;
      shownLast_q <= shownLast_d;
    end
  end

  // Output decode; stream fields are forced to zero outside EMIT
  always_comb begin
    busy_o          = (state_q != SQ_IDLE);
    done_o          = (state_q == SQ_DONE);
    start_perm_o    = startPerm;
    m_axis_tvalid_o = emitting;
    m_axis_tlast_o  = emitting && beatLast;
    m_axis_tdata_o  = emitting ? sliceData : '0;
    m_axis_tkeep_o  = emitting ? keepWide[OUT_BYTES-1:0] : '0;
  end

`ifdef ASCON_SQUEEZE_BYTECNT_EN
  logic [63:0] byteCount_q;

  // Running total of delivered bytes, restarted whenever a new squeeze is accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      byteCount_q <= '0;
    end else if ((state_q == SQ_IDLE) && start_i) begin
      byteCount_q <= '0;
    end else if (handshake) begin
      byteCount_q <= byteCount_q + 64'($countones(m_axis_tkeep_o));
    end
  end

  assign byte_count_o = byteCount_q;
`endif

endmodule

// File: tb/tb_ascon_squeeze_ctrl.sv
// Self-checking bench for ascon_squeeze_ctrl (OUT_BYTES = 4).
// A behavioural core model produces random rate words per permutation; the
// expected stream is the little-endian concatenation of those words, cut to
// the requested length or to the abort point.
// Checks byte_count_o as well when ASCON_SQUEEZE_BYTECNT_EN is defined.
module tb_ascon_squeeze_ctrl;

  localparam int OB        = 4;
  localparam int LEN_W     = 32;
  localparam int BLK_BEATS = 8 / OB;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [LEN_W-1:0] lenIn;
  logic            abort;
  logic            busy;
  logic            done;
  logic            coreReady;
  logic [63:0]     curRate;
  logic            startPerm;
  logic [8*OB-1:0] tdata;
  logic [OB-1:0]   tkeep;
  logic            tlast;
  logic            tvalid;
  logic            tready;
`ifdef ASCON_SQUEEZE_BYTECNT_EN
  logic [63:0]     byteCount;
`endif

  always #5 clk = ~clk;

  ascon_squeeze_ctrl #(
    .OUT_BYTES (OB),
    .LEN_W     (LEN_W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .start_i         (start),
    .len_i           (lenIn),
    .abort_i         (abort),
    .busy_o          (busy),
    .done_o          (done),
    .rate_i          (curRate),
    .ascon_ready_i   (coreReady),
    .start_perm_o    (startPerm),
    .m_axis_tdata_o  (tdata),
    .m_axis_tkeep_o  (tkeep),
    .m_axis_tlast_o  (tlast),
    .m_axis_tvalid_o (tvalid),
    .m_axis_tready_i (tready)
`ifdef ASCON_SQUEEZE_BYTECNT_EN
    ,
    .byte_count_o    (byteCount)
`endif
  );

  int vectors = 0;
  int miscompares = 0;
  int cycleNo = 0;

  int          coreCnt;
  logic [63:0] blocks[$];

  logic [8*OB-1:0] gotData[$];
  logic [OB-1:0]   gotKeep[$];
  logic            gotLast[$];
  int   permCount, doneCount, firstValidCycle, lastHsCycle, doneCycle;
  logic sawPerm;
  logic prevStall;
  logic [8*OB-1:0] prevData;
  logic [OB-1:0]   prevKeep;
  logic            prevLast;
  int   readyMode, stallFrom, testStart;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: update core model and tready after the edge, sample at negedge
  task automatic step();
    @(posedge clk);
    #1;
    cycleNo++;
    if (rst) begin
      coreReady = 1'b1;
      coreCnt   = 0;
    end else if (sawPerm) begin
      coreReady = 1'b0;
      coreCnt   = $urandom_range(1, 4);
    end else if (!coreReady) begin
      coreCnt--;
      if (coreCnt == 0) begin
        coreReady = 1'b1;
        curRate   = {$urandom(), $urandom()};
        blocks.push_back(curRate);
      end
    end
    case (readyMode)
      0:       tready = 1'b1;
      1:       tready = ($urandom_range(0, 3) != 0);
      default: tready = !(((cycleNo - testStart) >= stallFrom) &&
                          ((cycleNo - testStart) < stallFrom + 5));
    endcase
    @(negedge clk);
    sawPerm = startPerm;
    if (startPerm) permCount++;
    if (done) begin
      doneCount++;
      doneCycle = cycleNo;
    end
    if (prevStall) begin
      checkOutput("stall_tvalid", 64'(tvalid), 64'(1));
      checkOutput("stall_tdata", 64'(tdata), 64'(prevData));
      checkOutput("stall_tkeep", 64'(tkeep), 64'(prevKeep));
      checkOutput("stall_tlast", 64'(tlast), 64'(prevLast));
    end
    if (tvalid) begin
      if (firstValidCycle < 0) firstValidCycle = cycleNo;
      if (tready) begin
        gotData.push_back(tdata);
        gotKeep.push_back(tkeep);
        gotLast.push_back(tlast);
        if (tlast) lastHsCycle = cycleNo;
      end
    end
    prevStall = tvalid && !tready;
    prevData  = tdata;
    prevKeep  = tkeep;
    prevLast  = tlast;
  endtask

  // Run one squeeze and compare against the reference stream
  task automatic applyStimulus(input int len, input int mode, input int abortPerm);
    int   startCycle, budget, nBeats, expPerms, expBytes, idx;
    logic abortDone;
    logic [8*OB-1:0] ed;
    logic [OB-1:0]   ek;
    blocks.delete();
    blocks.push_back(curRate);
    gotData.delete();
    gotKeep.delete();
    gotLast.delete();
    permCount = 0;
    doneCount = 0;
    firstValidCycle = -1;
    lastHsCycle = -1;
    doneCycle = -1;
    prevStall = 1'b0;
    readyMode = mode;
    testStart = cycleNo;
    abortDone = 1'b0;

    start = 1'b1;
    lenIn = LEN_W'(len);
    step();
    start = 1'b0;
    startCycle = cycleNo;
    checkOutput("busy_after_start", 64'(busy), 64'(1));

    budget = 0;
    while (doneCount == 0 && budget < 3000) begin
      if (abortPerm > 0 && !abortDone && permCount == abortPerm && !coreReady) begin
        abort = 1'b1;
        abortDone = 1'b1;
      end
      step();
      abort = 1'b0;
      budget++;
    end
    checkOutput("done_seen", 64'(doneCount > 0), 64'(1));

    if (len == 0) begin
      nBeats   = abortPerm * BLK_BEATS + 1;
      expPerms = abortPerm;
      expBytes = nBeats * OB;
    end else begin
      nBeats   = (len + OB - 1) / OB;
      expPerms = (len + 7) / 8 - 1;
      expBytes = len;
    end
    checkOutput("beat_count", 64'(gotData.size()), 64'(nBeats));
    for (int b = 0; b < nBeats && b < gotData.size(); b++) begin
      ed = '0;
      ek = '0;
      for (int j = 0; j < OB; j++) begin
        idx = b * OB + j;
        if (idx / 8 < blocks.size()) ed[8*j +: 8] = blocks[idx/8][8*(idx%8) +: 8];
        ek[j] = (len == 0) || (idx < len);
      end
      checkOutput($sformatf("tdata[%0d]", b), 64'(gotData[b]), 64'(ed));
      checkOutput($sformatf("tkeep[%0d]", b), 64'(gotKeep[b]), 64'(ek));
      checkOutput($sformatf("tlast[%0d]", b), 64'(gotLast[b]), 64'(b == nBeats - 1));
    end
    checkOutput("perm_count", 64'(permCount), 64'(expPerms));
    checkOutput("first_valid_latency", 64'(firstValidCycle - startCycle), 64'(1));
    checkOutput("done_after_tlast", 64'(doneCycle - lastHsCycle), 64'(1));
`ifdef ASCON_SQUEEZE_BYTECNT_EN
    checkOutput("byte_count", byteCount, 64'(expBytes));
`else
    if (expBytes < 0) checkOutput("byte_total", 64'(expBytes), 64'(0));
`endif
    step();
    checkOutput("done_single", 64'(doneCount), 64'(1));
    checkOutput("busy_idle", 64'(busy), 64'(0));
  endtask

  task automatic checkQuiet(input string tag);
    checkOutput({tag, "_tvalid"}, 64'(tvalid), 64'(0));
    checkOutput({tag, "_tlast"}, 64'(tlast), 64'(0));
    checkOutput({tag, "_tdata"}, 64'(tdata), 64'(0));
    checkOutput({tag, "_tkeep"}, 64'(tkeep), 64'(0));
    checkOutput({tag, "_busy"}, 64'(busy), 64'(0));
    checkOutput({tag, "_done"}, 64'(done), 64'(0));
    checkOutput({tag, "_perm"}, 64'(startPerm), 64'(0));
`ifdef ASCON_SQUEEZE_BYTECNT_EN
    checkOutput({tag, "_bytecnt"}, byteCount, 64'(0));
`endif
  endtask

  // Directed sequence of squeezes, including backpressure, abort and reset cases
  initial begin
    int budget;
    rst = 1'b1;
    start = 1'b0;
    lenIn = '0;
    abort = 1'b0;
    tready = 1'b1;
    coreReady = 1'b1;
    coreCnt = 0;
    curRate = {$urandom(), $urandom()};
    sawPerm = 1'b0;
    prevStall = 1'b0;
    readyMode = 0;
    stallFrom = 3;
    testStart = 0;
    permCount = 0;
    doneCount = 0;
    firstValidCycle = -1;
    lastHsCycle = -1;
    doneCycle = -1;

    repeat (3) step();
    checkQuiet("reset");
    rst = 1'b0;
    step();

    $display("[TB] finite length tests");
    applyStimulus(32, 0, 0);
    applyStimulus(13, 0, 0);
    applyStimulus(1, 0, 0);
    applyStimulus(24, 2, 0);
    applyStimulus(20, 0, 1);

    $display("[TB] continuous mode with abort");
    applyStimulus(0, 0, 3);
    applyStimulus(0, 1, 2);

    $display("[TB] random lengths with random backpressure");
    for (int t = 0; t < 4; t++) begin
      applyStimulus($urandom_range(1, 40), 1, 0);
    end

    $display("[TB] reset during EMIT");
    readyMode = 0;
    start = 1'b1;
    lenIn = LEN_W'(64);
    step();
    start = 1'b0;
    budget = 0;
    while (!tvalid && budget < 20) begin
      step();
      budget++;
    end
    checkOutput("reach_emit", 64'(tvalid), 64'(1));
    step();
    rst = 1'b1;
    step();
    checkQuiet("midreset");
    rst = 1'b0;
    step();
    applyStimulus(8, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
